lane_motion_scheduler: RTL and testbench

//  Per-frame position sequencer for the 8 traffic lanes: 4 car rows and 4 lily-pad rows, 4 objects each.
//  - On each frame tick, one shared adder/wrap unit steps through all 32 objects, one per cycle.
//  - Updated positions go into a working buffer, then commit to the published X buses in a single cycle.
//  - The colour mapper therefore never sees a half-updated frame.
//  - Sits between the VGA frame-timing logic and color_mapper; drives the Car_RowN_X / LPad_RowN_X buses.

---
 rtl/lane_motion_scheduler.sv | 169 ++++++++++++++++
 tb/tb_lane_motion_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_motion_scheduler.sv
// Per-frame position sequencer for 8 traffic lanes x 4 objects. One shared
// next-position unit walks all 32 objects, then the frame is published in one edge.
module lane_motion_scheduler #(
    parameter int SCREEN_W  = 640,
    parameter int CAR_W     = 80,
    parameter int LPAD_W    = 40,
    parameter int OBJ_PITCH = 160
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_row,
    input  logic [2:0]       cfg_speed,
    input  logic             cfg_dir,
    input  logic [2:0]       cfg_count,
    output logic [3:0][10:0] Car_Row1_X,
    output logic [3:0][10:0] Car_Row2_X,
    output logic [3:0][10:0] Car_Row3_X,
    output logic [3:0][10:0] Car_Row4_X,
    output logic [3:0][10:0] LPad_Row1_X,
    output logic [3:0][10:0] LPad_Row2_X,
    output logic [3:0][10:0] LPad_Row3_X,
    output logic [3:0][10:0] LPad_Row4_X,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [10:0] SW  = 11'(SCREEN_W);
    localparam logic [10:0] CW  = 11'(CAR_W);
    localparam logic [10:0] LPW = 11'(LPAD_W);

    typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

    // live lane configuration
    logic [7:0][2:0] speed_q, speed_d, cnt_q, cnt_d;
    logic [7:0]      dir_q, dir_d;

    always_comb begin
        speed_d = speed_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        if (cfg_we) begin
            speed_d[cfg_row] = cfg_speed;
            dir_d[cfg_row]   = cfg_dir;
            cnt_d[cfg_row]   = (cfg_count > 3'd4) ? 3'd4 : cfg_count;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int l = 0; l < 8; l++) begin
                speed_q[l] <= 3'd1;
                dir_q[l]   <= 1'b0;
                cnt_q[l]   <= 3'd4;
            end
        end else begin
            speed_q <= speed_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    state_t           state_q;
    logic [4:0]       idx_q;
    logic [7:0][2:0]  snap_spd_q, snap_cnt_q;
    logic [7:0]       snap_dir_q;
    logic [31:0][10:0] wx_q, pub_q;
    logic [10:0]      nx_q;
    logic [4:0]       widx_q;
    logic             wvld_q;
    logic             busy_q, done_q, overrun_q;

    // shared adder/wrap unit for the object at idx_q
    logic [2:0]  lane;
    logic [1:0]  obj;
    logic [2:0]  spd;
    logic [10:0] x_cur, x_nxt, n, w;

    always_comb begin
        lane  = idx_q[4:2];
        obj   = idx_q[1:0];
        spd   = snap_spd_q[lane];
        x_cur = wx_q[idx_q];
        w     = lane[2] ? LPW : CW;
        n     = x_cur;
        x_nxt = x_cur;
        if (({1'b0, obj} < snap_cnt_q[lane]) && (spd != 3'd0)) begin
            if (!snap_dir_q[lane]) begin
                n = x_cur + {8'd0, spd};
                if (n >= SW && n <= 11'd1023) n = n - (SW + w);
            end else begin
                n = x_cur - {8'd0, spd};
                if (n >= 11'd1024 && n <= (11'd2047 - w)) n = n + (SW + w);
            end
            x_nxt = n;
        end
    end

    // Result of the shared unit is registered and written back a cycle later;
    // COMMIT waits for that last writeback before publishing.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            idx_q      <= 5'd0;
            nx_q       <= 11'd0;
            widx_q     <= 5'd0;
            wvld_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            snap_spd_q <= '0;
            snap_dir_q <= '0;
            snap_cnt_q <= '0;
            for (int k = 0; k < 32; k++) begin
                wx_q[k]  <= 11'((k % 4) * OBJ_PITCH);
                pub_q[k] <= 11'((k % 4) * OBJ_PITCH);
            end
        end else begin
            done_q <= 1'b0;
            wvld_q <= 1'b0;
            if (wvld_q) wx_q[widx_q] <= nx_q;
            if (frame_tick && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (frame_tick && !pause) begin
                        snap_spd_q <= speed_d;
                        snap_dir_q <= dir_d;
                        snap_cnt_q <= cnt_d;
                        idx_q      <= 5'd0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    busy_q <= 1'b1;
                    nx_q   <= x_nxt;
                    widx_q <= idx_q;
                    wvld_q <= 1'b1;
                    idx_q  <= idx_q + 5'd1;
                    if (idx_q == 5'd31) state_q <= COMMIT;
                end
                COMMIT: begin
                    if (!wvld_q) begin
                        pub_q   <= wx_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Car_Row1_X  = pub_q[3:0];
    assign Car_Row2_X  = pub_q[7:4];
    assign Car_Row3_X  = pub_q[11:8];
    assign Car_Row4_X  = pub_q[15:12];
    assign LPad_Row1_X = pub_q[19:16];
    assign LPad_Row2_X = pub_q[23:20];
    assign LPad_Row3_X = pub_q[27:24];
    assign LPad_Row4_X = pub_q[31:28];
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_lane_motion_scheduler.sv
// Scoreboard bench: each accepted tick pushes the expected published frame;
// a monitor pops and compares whenever done pulses.
module tb_lane_motion_scheduler;
    logic Clk = 0, Reset = 1, frame_tick = 0, pause = 0, cfg_we = 0, cfg_dir = 0;
    logic [2:0] cfg_row = 0, cfg_speed = 0, cfg_count = 0;
    logic [3:0][10:0] c1, c2, c3, c4, p1, p2, p3, p4;
    logic busy, done, overrun;

    lane_motion_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .pause(pause),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_speed(cfg_speed), .cfg_dir(cfg_dir),
        .cfg_count(cfg_count),
        .Car_Row1_X(c1), .Car_Row2_X(c2), .Car_Row3_X(c3), .Car_Row4_X(c4),
        .LPad_Row1_X(p1), .LPad_Row2_X(p2), .LPad_Row3_X(p3), .LPad_Row4_X(p4),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    logic [31:0][10:0] dut_all;
    assign dut_all = {p4, p3, p2, p1, c4, c3, c2, c1};

    typedef struct { logic [31:0][10:0] pos; int tcyc; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, cyc = 0, n_done = 0;
    int m_pos[32], m_spd[8], m_dir[8], m_cnt[8];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // reference step in the signed pixel domain
    function automatic int mnext(int x, int spd, int dir, int lane);
        int xs, w;
        xs = (x >= 1024) ? x - 2048 : x;
        w  = (lane < 4) ? 80 : 40;
        if (spd == 0) return x;
        if (dir == 0) begin
            xs = xs + spd;
            if (xs >= 640) xs = xs - (640 + w);
        end else begin
            xs = xs - spd;
            if (xs < -w) xs = xs + (640 + w);
        end
        return (xs + 2048) % 2048;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_pos[k] = (k % 4) * 160;
        for (int l = 0; l < 8; l++) begin m_spd[l] = 1; m_dir[l] = 0; m_cnt[l] = 4; end
        sb.delete();
    endtask

    task automatic set_cfg(int row, int spd, int dir, int cnt);
        cfg_we = 1; cfg_row = 3'(row); cfg_speed = 3'(spd); cfg_dir = dir[0]; cfg_count = 3'(cnt);
        m_spd[row] = spd; m_dir[row] = dir; m_cnt[row] = (cnt > 4) ? 4 : cnt;
    endtask

    task automatic cfg(int row, int spd, int dir, int cnt);
        @(posedge Clk); #1;
        set_cfg(row, spd, dir, cnt);
        @(posedge Clk); #1;
        cfg_we = 0;
    endtask

    task automatic tick(bit wcfg = 0, int row = 0, int spd = 0, int dir = 0, int cnt = 0);
        exp_t e;
        @(posedge Clk); #1;
        frame_tick = 1;
        if (wcfg) set_cfg(row, spd, dir, cnt);
        for (int k = 0; k < 32; k++) begin
            if ((k % 4) < m_cnt[k / 4]) m_pos[k] = mnext(m_pos[k], m_spd[k / 4], m_dir[k / 4], k / 4);
            e.pos[k] = 11'(m_pos[k]);
        end
        e.tcyc = cyc + 1;
        sb.push_back(e);
        @(posedge Clk); #1;
        frame_tick = 0; cfg_we = 0;
    endtask

    task automatic pulse_tick();
        @(posedge Clk); #1; frame_tick = 1;
        @(posedge Clk); #1; frame_tick = 0;
    endtask

    task automatic wait_frames();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin @(posedge Clk); t++; end
        if (t >= 200) begin chk("frame_timeout", 1, 0); sb.delete(); end
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(posedge Clk); #2;
        Reset = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Reset = 1;
    endtask

    task automatic chk_reset_vals(string nm);
        logic [31:0][10:0] rv;
        for (int k = 0; k < 32; k++) rv[k] = 11'((k % 4) * 160);
        for (int l = 0; l < 8; l++)
            chk($sformatf("%s_lane%0d", nm, l), longint'(dut_all[4*l +: 4]), longint'(rv[4*l +: 4]));
        chk({nm, "_busy"}, longint'(busy), 0);
        chk({nm, "_done"}, longint'(done), 0);
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset && done) begin
            n_done++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                for (int l = 0; l < 8; l++)
                    chk($sformatf("frame_lane%0d", l), longint'(dut_all[4*l +: 4]), longint'(e.pos[4*l +: 4]));
                chk("done_latency", longint'(cyc - e.tcyc), 34);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        // T1 reset
        #1 Reset = 0;
        model_reset();
        #3;
        chk_reset_vals("t1_rst");
        chk("t1_overrun", longint'(overrun), 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1;
        repeat (5) @(negedge Clk);
        chk("t1_idle_busy", longint'(busy), 0);
        chk("t1_idle_done_cnt", n_done, 0);

        // T2 right wrap on lane 0, object 3
        cfg(0, 7, 0, 4);
        for (int f = 0; f < 22; f++) begin tick(); wait_frames(); end
        chk("t2_x634", longint'(c1[3]), 634);
        cfg(0, 4, 0, 4);
        tick(); wait_frames();
        chk("t2_x638", longint'(c1[3]), 638);
        cfg(0, 3, 0, 4);
        tick(); wait_frames();
        chk("t2_wrap1969", longint'(c1[3]), 1969);

        // T3 left wrap on lane 4, object 0
        do_reset();
        cfg(4, 7, 1, 4);
        for (int f = 0; f < 5; f++) begin tick(); wait_frames(); end
        cfg(4, 4, 1, 4);
        tick(); wait_frames();
        chk("t3_x2009", longint'(p1[0]), 2009);
        cfg(4, 2, 1, 4);
        tick(); wait_frames();
        chk("t3_wrap639", longint'(p1[0]), 639);

        // T4 count / speed 0 / saturation / cfg coincident with tick
        do_reset();
        cfg(2, 1, 0, 2);
        cfg(1, 0, 0, 4);
        cfg(3, 1, 0, 7);
        cfg(5, 1, 0, 0);
        tick(1, 6, 3, 0, 4);
        wait_frames();
        chk("t4_cnt2", longint'(c3), longint'({11'd480, 11'd320, 11'd161, 11'd1}));
        chk("t4_spd0", longint'(c2), longint'({11'd480, 11'd320, 11'd160, 11'd0}));
        chk("t4_cnt_sat", longint'(c4), longint'({11'd481, 11'd321, 11'd161, 11'd1}));
        chk("t4_cnt0", longint'(p2), longint'({11'd480, 11'd320, 11'd160, 11'd0}));
        chk("t4_same_cycle_cfg", longint'(p3[0]), 3);

        // T5 overrun and pause
        do_reset();
        d0 = n_done;
        tick();
        repeat (10) @(posedge Clk);
        #1 frame_tick = 1;
        @(posedge Clk); #1 frame_tick = 0;
        @(negedge Clk);
        chk("t5_overrun_set", longint'(overrun), 1);
        wait_frames();
        repeat (40) @(negedge Clk);
        chk("t5_single_done", n_done - d0, 1);
        chk("t5_overrun_sticky", longint'(overrun), 1);
        do_reset();
        d0 = n_done;
        pause = 1;
        pulse_tick();
        repeat (3) @(negedge Clk);
        chk("t5_pause_busy", longint'(busy), 0);
        chk("t5_pause_overrun", longint'(overrun), 0);
        pause = 0;
        repeat (40) @(negedge Clk);
        chk("t5_pause_no_done", n_done - d0, 0);

        // T6 async reset mid-RUN, then mid-frame cfg write
        do_reset();
        d0 = n_done;
        tick();
        repeat (15) @(posedge Clk);
        #3 Reset = 0;
        #1;
        chk_reset_vals("t6_rst");
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Reset = 1;
        repeat (50) @(negedge Clk);
        chk("t6_no_partial_done", n_done - d0, 0);
        tick();
        repeat (5) @(posedge Clk);
        cfg(0, 5, 0, 4);
        wait_frames();
        chk("t6_old_speed", longint'(c1[0]), 1);
        tick(); wait_frames();
        chk("t6_new_speed", longint'(c1[0]), 6);

        repeat (5) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
